// File: rtl/cla_pkg.sv
// Shared definitions for the iterative carry-lookahead adder:
// FSM state encodings and the width of the reused adder slice.
package cla_pkg;

  localparam int unsigned SLICE_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } cla_state_e;

endpackage

// File: rtl/cla_slice_4bit.sv
// Combinational 4-bit carry-lookahead slice: every internal carry is formed
// directly from propagate/generate terms and the slice carry-in.
module cla_slice_4bit (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       ci,
  output logic [3:0] s,
  output logic       c3,
  output logic       c2
);

  logic [3:0] p;
  logic [3:0] g;
  logic       c0;
  logic       c1;

  always_comb begin
    p  = a ^ b;
    g  = a & b;
    c0 = g[0] | (p[0] & ci);
    c1 = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
    c2 = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & ci);
    c3 = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
       | (p[3] & p[2] & p[1] & p[0] & ci);
    s  = p ^ {c2, c1, c0, ci};
  end

endmodule

// File: rtl/cla_seq_adder.sv
// Iterative WIDTH-bit adder/subtractor: one 4-bit lookahead slice is reused
// LSB nibble first, with the slice carry-out registered between cycles.
module cla_seq_adder
  import cla_pkg::*;
#(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             busy,
  output logic             done
);

  localparam int unsigned N     = WIDTH / SLICE_W;
  localparam int unsigned IDX_W = $clog2(N);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

  cla_state_e       state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;

  logic [SLICE_W-1:0] slice_a;
  logic [SLICE_W-1:0] slice_b;
  logic [SLICE_W-1:0] slice_s;
  logic               slice_c3;
  logic               slice_c2;

  assign slice_a = a_q[idx_q*SLICE_W +: SLICE_W];
  assign slice_b = b_q[idx_q*SLICE_W +: SLICE_W];

  cla_slice_4bit u_slice (
    .a  (slice_a),
    .b  (slice_b),
    .ci (carry_q),
    .s  (slice_s),
    .c3 (slice_c3),
    .c2 (slice_c2)
  );

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    idx_d   = idx_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;

    unique case (state_q)
      IDLE, DONE: begin
        if (start) begin
          // Subtract is A + ~B + 1; B is stored pre-inverted so RUN is add-only.
          state_d = RUN;
          a_d     = a;
          b_d     = sub ? ~b : b;
          carry_d = sub ? 1'b1 : cin;
          idx_d   = '0;
          sum_d   = '0;
          cout_d  = 1'b0;
          ovf_d   = 1'b0;
        end else if (state_q == DONE) begin
          state_d = IDLE;
        end
      end
      RUN: begin
        sum_d[idx_q*SLICE_W +: SLICE_W] = slice_s;
        carry_d = slice_c3;
        idx_d   = idx_q + 1'b1;
        if (idx_q == LAST_IDX) begin
          state_d = DONE;
          idx_d   = '0;
          cout_d  = slice_c3;
          ovf_d   = slice_c3 ^ slice_c2;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      idx_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  assign sum  = sum_q;
  assign cout = cout_q;
  assign ovf  = ovf_q;
  assign busy = (state_q == RUN);
  assign done = (state_q == DONE);

endmodule

// File: tb/tb_cla_seq_adder.sv
// Self-checking bench for cla_seq_adder (WIDTH = 16): vector table, random
// operands against an arithmetic model, and hand-written handshake sequences.
module tb_cla_seq_adder;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        sub;
  logic        cin;
  logic [15:0] a;
  logic [15:0] b;
  logic [15:0] sum;
  logic        cout;
  logic        ovf;
  logic        busy;
  logic        done;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        sub;
    logic        cin;
    logic [15:0] s;
    logic        co;
    logic        ov;
  } vec_t;

  vec_t q[$];

  cla_seq_adder #(.WIDTH(16)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .sub   (sub),
    .a     (a),
    .b     (b),
    .cin   (cin),
    .sum   (sum),
    .cout  (cout),
    .ovf   (ovf),
    .busy  (busy),
    .done  (done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic vec_t model(input logic [15:0] va, input logic [15:0] vb,
                                 input logic vsub, input logic vcin);
    vec_t        v;
    logic [15:0] bb;
    logic [16:0] full;
    bb     = vsub ? ~vb : vb;
    full   = {1'b0, va} + {1'b0, bb} + {16'd0, (vsub ? 1'b1 : vcin)};
    v.a    = va;
    v.b    = vb;
    v.sub  = vsub;
    v.cin  = vcin;
    v.s    = full[15:0];
    v.co   = full[16];
    v.ov   = (va[15] == bb[15]) && (full[15] != va[15]);
    return v;
  endfunction

  task automatic drive(input vec_t v);
    a   = v.a;
    b   = v.b;
    sub = v.sub;
    cin = v.cin;
  endtask

  task automatic check_result(input string tag);
    vec_t v;
    if (q.size() == 0) begin
      chk({tag, "_queue_nonempty"}, 0, 1);
    end else begin
      v = q.pop_front();
      chk({tag, "_sum"}, sum, v.s);
      chk({tag, "_cout"}, cout, v.co);
      chk({tag, "_ovf"}, ovf, v.ov);
    end
  endtask

  // Waits (bounded) for done; returns cycles since the accepting edge.
  task automatic wait_done(output int cyc, output int busy_n, output bit got);
    cyc = 0; busy_n = 0; got = 1'b0;
    repeat (20) begin
      @(negedge clk);
      start = 1'b0;
      cyc++;
      if (busy) busy_n++;
      if (done) begin
        got = 1'b1;
        break;
      end
    end
  endtask

  task automatic do_op(input vec_t v, input string tag);
    int cyc;
    int busy_n;
    bit got;
    @(negedge clk);
    drive(v);
    start = 1'b1;
    q.push_back(v);
    @(negedge clk);
    start = 1'b0;
    a = 16'($urandom);
    b = 16'($urandom);
    sub = 1'($urandom);
    cin = 1'($urandom);
    cyc = 1; busy_n = busy ? 1 : 0; got = 1'b0;
    if (!done) begin
      int c2;
      int b2;
      wait_done(c2, b2, got);
      cyc += c2;
      busy_n += b2;
    end
    chk({tag, "_done_seen"}, got, 1);
    chk({tag, "_latency"}, cyc, 5);
    chk({tag, "_busy_cycles"}, busy_n, 4);
    check_result(tag);
    @(negedge clk);
    chk({tag, "_done_pulse"}, done, 0);
    chk({tag, "_idle_busy"}, busy, 0);
    chk({tag, "_hold_sum"}, sum, v.s);
  endtask

  vec_t tbl[8];
  vec_t b2b[4];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    int busy_n;
    int dones;
    bit got;
    vec_t v;

    tbl[0] = '{16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0};
    tbl[1] = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0};
    tbl[2] = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1};
    tbl[3] = '{16'h0005, 16'h0007, 1'b1, 1'b0, 16'hFFFE, 1'b0, 1'b0};
    tbl[4] = '{16'h8000, 16'h0001, 1'b1, 1'b0, 16'h7FFF, 1'b1, 1'b1};
    tbl[5] = '{16'hABCD, 16'h1234, 1'b0, 1'b1, 16'hBE02, 1'b0, 1'b0};
    tbl[6] = '{16'h0000, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0};
    tbl[7] = '{16'h0010, 16'h0001, 1'b1, 1'b1, 16'h000F, 1'b1, 1'b0};

    b2b[0] = '{16'h1111, 16'h2222, 1'b0, 1'b0, 16'h3333, 1'b0, 1'b0};
    b2b[1] = '{16'hF000, 16'h1000, 1'b0, 1'b1, 16'h0001, 1'b1, 1'b0};
    b2b[2] = '{16'h0100, 16'h0200, 1'b1, 1'b0, 16'hFF00, 1'b0, 1'b0};
    b2b[3] = '{16'h4000, 16'h4000, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1};

    rst = 1'b1; start = 1'b0; sub = 1'b0; cin = 1'b0; a = '0; b = '0;
    repeat (3) @(negedge clk);
    chk("reset_sum", sum, 0);
    chk("reset_cout", cout, 0);
    chk("reset_ovf", ovf, 0);
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    rst = 1'b0;

    for (int i = 0; i < 8; i++) do_op(tbl[i], $sformatf("tbl%0d", i));

    for (int i = 0; i < 6; i++) begin
      v = model(16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom));
      do_op(v, $sformatf("rnd%0d", i));
    end

    // start pulsed during RUN must be ignored
    @(negedge clk);
    v = tbl[0];
    drive(v);
    start = 1'b1;
    q.push_back(v);
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    a = 16'hFFFF; b = 16'hFFFF; sub = 1'b1; cin = 1'b1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(cyc, busy_n, got);
    chk("ign_done_seen", got, 1);
    chk("ign_latency", cyc + 3, 5);
    check_result("ign");
    dones = 0;
    repeat (10) begin
      @(negedge clk);
      if (done) dones++;
    end
    chk("ign_no_second_done", dones, 0);
    chk("ign_hold_sum", sum, 16'h5555);

    // reset after the second RUN cycle, with start also high (reset wins)
    @(negedge clk);
    a = 16'h1234; b = 16'h1111; sub = 1'b0; cin = 1'b0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    start = 1'b1;
    @(negedge clk);
    chk("midrst_sum", sum, 0);
    chk("midrst_cout", cout, 0);
    chk("midrst_ovf", ovf, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_done", done, 0);
    rst = 1'b0;
    start = 1'b0;
    dones = 0;
    repeat (6) begin
      @(negedge clk);
      if (done || busy) dones++;
    end
    chk("midrst_stays_idle", dones, 0);
    do_op(model(16'h00FF, 16'h0001, 1'b0, 1'b0), "post_rst");
    chk("post_rst_const", sum, 16'h0100);

    // start held high: new operands presented in each DONE cycle
    @(negedge clk);
    drive(b2b[0]);
    start = 1'b1;
    q.push_back(b2b[0]);
    for (int k = 0; k < 4; k++) begin
      cyc = 0; got = 1'b0;
      repeat (20) begin
        @(negedge clk);
        cyc++;
        if (done) begin
          got = 1'b1;
          break;
        end
      end
      chk($sformatf("b2b%0d_done_seen", k), got, 1);
      chk($sformatf("b2b%0d_interval", k), cyc, 5);
      check_result($sformatf("b2b%0d", k));
      if (k < 3) begin
        drive(b2b[k+1]);
        q.push_back(b2b[k+1]);
      end else begin
        start = 1'b0;
      end
    end
    @(negedge clk);
    chk("b2b_final_idle", busy | done, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
